regfile_bank: RTL and testbench
===============================

Name: regfile_bank

Overview:
- Parametrised RTL register bank for DMA-write-side control/status registers; the synthesizable counterpart of the team's register-file object model.
- Generalises the fixed-layout register block: register count, data width and per-register access mode (RW, RO, W1C, RC) are all parameters.
- Sits between the host register bus (Avalon-MM-like slave) and the DMA write engine.
- Provides one-cycle registered reads, byte-enabled writes, hardware status set inputs, per-register access strobes, and an error response for out-of-range or illegal accesses.

Parameters:
- NREG, 16, number of registers (1..256).
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 8, byte-address width; word index = reg_addr[ADDR_W-1:log2(DATA_W/8)].
- MODE, all RW, NREG*2-bit packed vector, 2 bits per register: 0=RW, 1=RO, 2=W1C, 3=RC.
- RESET_VAL, 0, NREG*DATA_W packed reset values.

Ports:
- sysclk  in  1  clock.
- sysrst_n  in  1  reset, asynchronous, active-low.
- reg_addr  in  ADDR_W  byte address.
- reg_read  in  1  read request.
- reg_write  in  1  write request.
- reg_be  in  DATA_W/8  byte enables.
- reg_writedata  in  DATA_W  write data.
- reg_waitrequest  out  1  stall; a request is accepted when it is asserted and waitrequest=0.
- reg_readdata  out  DATA_W  read data.
- reg_readdatavalid  out  1  read data valid.
- reg_error  out  1  one-cycle pulse for a failed access.
- hw_set  in  NREG*DATA_W  per-bit set (W1C/RC regs) or live value (RO regs).
- reg_q  out  NREG*DATA_W  current register contents.
- reg_wstrobe  out  NREG  one-cycle pulse: register written.
- reg_rstrobe  out  NREG  one-cycle pulse: register read.

Behaviour:
- Reset, asynchronous on sysrst_n low:
  - storage = RESET_VAL;
  - reg_readdata = 0, reg_readdatavalid = 0, reg_error = 0, reg_waitrequest = 0;
  - all strobes = 0; state = IDLE.
- States: IDLE, RD_RESP, WR_HOLD.
- IDLE:
  - Accepted write → commit on the same edge, pulse reg_wstrobe[idx] next cycle, stay IDLE.
  - Accepted read → capture data, go to RD_RESP.
  - reg_read and reg_write together: the write is accepted, reg_waitrequest is asserted for one cycle (state WR_HOLD), and the read is accepted in the following cycle.
- RD_RESP:
  - reg_readdatavalid = 1 for exactly one cycle; read latency is 1 cycle after acceptance.
  - reg_rstrobe[idx] pulses in the same cycle.
  - reg_waitrequest = 1 while in RD_RESP, so back-to-back reads accept every 2 cycles.
  - Returns to IDLE.
- Write semantics, byte-lane masked by reg_be:
  - RW: bits replaced.
  - RO: write ignored, reg_error pulses.
  - W1C: bits with writedata=1 are cleared.
  - RC: write ignored, reg_error pulses.
- Read semantics:
  - RO returns hw_set slice (live).
  - RC returns the value, then clears the register on the response edge.
  - Others return the stored value.
- hw_set for W1C/RC registers ORs into storage every cycle. A set wins over a same-cycle clear (W1C write or RC read-clear) on the same bit.
- Out of range (idx ≥ NREG):
  - write is dropped; read returns 0 with readdatavalid = 1.
  - reg_error pulses with the response; no strobe.
- reg_be = 0 on a write: no change, strobe still pulses.
- Reset mid-read: response is aborted; no readdatavalid after reset release.

Decomposition:
- Shared package regfile_bank_pkg:
  - access-mode enum (RW, RO, W1C, RC);
  - state enum;
  - function for the per-bit next-value rule.
- One sub-module, regfile_cell: a single register that applies mode, byte enables, hw_set and clear priority. Generated NREG times; the top level holds the FSM, address decode and read mux.

Test Plan:
- Reset value check: RESET_VAL reg2 = 0x0000_00A5, deassert reset, read addr 0x08 → readdata 0x0000_00A5 one cycle after acceptance, readdatavalid for 1 cycle, rstrobe[2] = 1.
- Byte-enable RW write: reg0 = 0x1111_1111, write 0xAABB_CCDD with be = 4'b0101 → reg_q[0] = 0x11BB_11DD, wstrobe[0] pulses once.
- W1C set/clear race:
  - hw_set[3] bit4 pulses → read returns 0x10;
  - write 0x10 to reg3 while hw_set bit4 is high → bit stays 1;
  - repeat with hw_set low → reads 0x0.
- RC clear-on-read: hw_set sets reg5 = 0x3 → first read returns 0x3, second read returns 0x0.
- Illegal accesses, NREG = 16:
  - read 0x40 → readdata 0, reg_error with valid;
  - write to an RO register → value unchanged, reg_error pulses.
- Simultaneous read+write to reg1:
  - write accepted first;
  - waitrequest high for 1 cycle;
  - read returns the newly written value;
  - sysrst_n asserted during RD_RESP → no readdatavalid after release.

Source files
------------

// File: rtl/regfile_bank_pkg.sv
// regfile_bank_pkg: access modes, bus FSM states and the per-bit next-value rule
// shared by the register bank and its cells.
package regfile_bank_pkg;

    typedef enum logic [1:0] {RW = 2'd0, RO = 2'd1, W1C = 2'd2, RC = 2'd3} acc_mode_e;

    typedef enum logic [1:0] {IDLE, RD_RESP, WR_HOLD} state_e;

    // A hardware set always beats a same-cycle clear on the same bit.
    function automatic logic next_bit(input acc_mode_e m, input logic cur, input logic wen,
                                      input logic wd, input logic hs, input logic rclr);
        return (m == RW)  ? (wen ? wd : cur) :
               (m == RO)  ? cur :
               (m == W1C) ? (hs | (cur & ~(wen & wd))) :
                            (hs | (cur & ~rclr));
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell: one register of the bank; applies access mode, byte enables,
// hardware set and read-clear with set-over-clear priority.
module regfile_cell
    import regfile_bank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter acc_mode_e         MODE      = RW,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    input  logic                we,
    input  logic                rc_clr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   hw_set,
    output logic [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] val_d, val_q;

    always_comb begin
        val_d = val_q;
        for (int i = 0; i < DATA_W; i++)
            val_d[i] = next_bit(MODE, val_q[i], we & be[i/8], wdata[i], hw_set[i], rc_clr);
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) val_q <= RESET_VAL;
        else           val_q <= val_d;
    end

    // Read-only registers expose the live hardware value.
    assign q = (MODE == RO) ? hw_set : val_q;

endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: parametrised host-facing control/status register bank with
// registered one-cycle reads, byte-enabled writes and error responses.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int                       NREG      = 16,
    parameter int                       DATA_W    = 32,
    parameter int                       ADDR_W    = 8,
    parameter logic [NREG*2-1:0]        MODE      = '0,
    parameter logic [NREG*DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                     sysclk,
    input  logic                     sysrst_n,
    input  logic [ADDR_W-1:0]        reg_addr,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic [DATA_W/8-1:0]      reg_be,
    input  logic [DATA_W-1:0]        reg_writedata,
    output logic                     reg_waitrequest,
    output logic [DATA_W-1:0]        reg_readdata,
    output logic                     reg_readdatavalid,
    output logic                     reg_error,
    input  logic [NREG*DATA_W-1:0]   hw_set,
    output logic [NREG*DATA_W-1:0]   reg_q,
    output logic [NREG-1:0]          reg_wstrobe,
    output logic [NREG-1:0]          reg_rstrobe
);

    localparam int LSB = $clog2(DATA_W / 8);
    localparam int IW  = ADDR_W - LSB;

    state_e            state_q;
    logic              wait_q, rvalid_q, err_q;
    logic [DATA_W-1:0] rdata_q, rd_val;
    logic [NREG-1:0]   wstb_q, rstb_q, we, wr_sel, rd_sel;
    logic [IW-1:0]     idx, hidx_q, rd_idx;
    logic              wr_hit, rd_hit, wr_ok;
    acc_mode_e         wr_mode;

    generate
        if (LSB > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^reg_addr[LSB-1:0];
        end
    endgenerate

    assign idx    = reg_addr[ADDR_W-1:LSB];
    assign rd_idx = (state_q == WR_HOLD) ? hidx_q : idx;

    // Decode by comparison so out-of-range indices simply miss every register.
    always_comb begin
        wr_hit  = 1'b0;
        wr_mode = RW;
        wr_sel  = '0;
        rd_hit  = 1'b0;
        rd_val  = '0;
        rd_sel  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IW'(i)) begin
                wr_hit    = 1'b1;
                wr_mode   = acc_mode_e'(MODE[2*i +: 2]);
                wr_sel[i] = 1'b1;
            end
            if (rd_idx == IW'(i)) begin
                rd_hit    = 1'b1;
                rd_val    = reg_q[i*DATA_W +: DATA_W];
                rd_sel[i] = 1'b1;
            end
        end
    end

    assign wr_ok = wr_hit && (wr_mode == RW || wr_mode == W1C);
    assign we    = (state_q == IDLE && reg_write && wr_ok) ? wr_sel : '0;

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        regfile_cell #(
            .DATA_W   (DATA_W),
            .MODE     (acc_mode_e'(MODE[2*i +: 2])),
            .RESET_VAL(RESET_VAL[i*DATA_W +: DATA_W])
        ) u_cell (
            .sysclk  (sysclk),
            .sysrst_n(sysrst_n),
            .we      (we[i]),
            .rc_clr  (rstb_q[i]),
            .be      (reg_be),
            .wdata   (reg_writedata),
            .hw_set  (hw_set[i*DATA_W +: DATA_W]),
            .q       (reg_q[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q  <= IDLE;
            wait_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            wstb_q   <= '0;
            rstb_q   <= '0;
            hidx_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            wstb_q   <= '0;
            rstb_q   <= '0;
            if ((state_q == IDLE && reg_read && !reg_write) || state_q == WR_HOLD) begin
                state_q  <= RD_RESP;
                wait_q   <= 1'b1;
                rvalid_q <= 1'b1;
                err_q    <= !rd_hit;
                rdata_q  <= rd_val;
                rstb_q   <= rd_sel;
            end else if (state_q == IDLE && reg_write) begin
                err_q  <= !wr_ok;
                wstb_q <= wr_ok ? wr_sel : '0;
                hidx_q <= idx;
                if (reg_read) begin
                    state_q <= WR_HOLD;
                    wait_q  <= 1'b1;
                end
            end else if (state_q == RD_RESP) begin
                state_q <= IDLE;
                wait_q  <= 1'b0;
            end
        end
    end

    assign reg_waitrequest   = wait_q;
    assign reg_readdata      = rdata_q;
    assign reg_readdatavalid = rvalid_q;
    assign reg_error         = err_q;
    assign reg_wstrobe       = wstb_q;
    assign reg_rstrobe       = rstb_q;

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed checks of regfile_bank with hand-computed expectations.
// Map: reg2 RW reset 0xA5, reg3 W1C, reg4 RO, reg5 RC, all others RW.
module tb_regfile_bank;

    localparam int NREG = 16;
    localparam int DW   = 32;
    localparam logic [NREG*2-1:0]  MODE = 32'h0000_0D80;
    localparam logic [NREG*DW-1:0] RV   = 512'hA5 << 64;

    logic               sysclk = 1'b0;
    logic               sysrst_n = 1'b1;
    logic [7:0]         reg_addr = '0;
    logic               reg_read = 1'b0;
    logic               reg_write = 1'b0;
    logic [3:0]         reg_be = '0;
    logic [DW-1:0]      reg_writedata = '0;
    logic               reg_waitrequest;
    logic [DW-1:0]      reg_readdata;
    logic               reg_readdatavalid;
    logic               reg_error;
    logic [NREG*DW-1:0] hw_set = '0;
    logic [NREG*DW-1:0] reg_q;
    logic [NREG-1:0]    reg_wstrobe;
    logic [NREG-1:0]    reg_rstrobe;

    int checks = 0;
    int errs   = 0;

    regfile_bank #(.NREG(NREG), .DATA_W(DW), .ADDR_W(8), .MODE(MODE), .RESET_VAL(RV)) dut (
        .sysclk           (sysclk),
        .sysrst_n         (sysrst_n),
        .reg_addr         (reg_addr),
        .reg_read         (reg_read),
        .reg_write        (reg_write),
        .reg_be           (reg_be),
        .reg_writedata    (reg_writedata),
        .reg_waitrequest  (reg_waitrequest),
        .reg_readdata     (reg_readdata),
        .reg_readdatavalid(reg_readdatavalid),
        .reg_error        (reg_error),
        .hw_set           (hw_set),
        .reg_q            (reg_q),
        .reg_wstrobe      (reg_wstrobe),
        .reg_rstrobe      (reg_rstrobe)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] qw(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_write(input logic [7:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        reg_addr = a; reg_be = be; reg_writedata = d; reg_write = 1'b1;
        @(posedge sysclk); #1;
        reg_write = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [DW-1:0] exp_d,
                           input logic exp_err, input logic [NREG-1:0] exp_rs);
        chk({tag, "_idle_wait"}, reg_waitrequest, 1'b0);
        reg_addr = a; reg_read = 1'b1;
        @(posedge sysclk); #1;
        reg_read = 1'b0;
        chk({tag, "_valid"}, reg_readdatavalid, 1'b1);
        chk({tag, "_data"}, reg_readdata, exp_d);
        chk({tag, "_err"}, reg_error, exp_err);
        chk({tag, "_rstb"}, reg_rstrobe, exp_rs);
        @(posedge sysclk); #1;
        chk({tag, "_valid_drop"}, reg_readdatavalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_valid;
        #2 sysrst_n = 1'b0;
        #1;
        chk("rst_rdata", reg_readdata, '0);
        chk("rst_valid", reg_readdatavalid, 1'b0);
        chk("rst_err", reg_error, 1'b0);
        chk("rst_wait", reg_waitrequest, 1'b0);
        chk("rst_wstb", reg_wstrobe, '0);
        chk("rst_rstb", reg_rstrobe, '0);
        chk("rst_reg2", qw(2), 32'h0000_00A5);
        repeat (2) @(posedge sysclk);
        #1 sysrst_n = 1'b1;
        @(posedge sysclk); #1;

        do_read("rd_reset", 8'h08, 32'h0000_00A5, 1'b0, 16'h0004);

        do_write(8'h00, 4'hF, 32'h1111_1111);
        do_write(8'h00, 4'b0101, 32'hAABB_CCDD);
        chk("be_val", qw(0), 32'h11BB_11DD);
        chk("be_wstb", reg_wstrobe, 16'h0001);
        chk("be_err", reg_error, 1'b0);
        @(posedge sysclk); #1;
        chk("be_wstb_once", reg_wstrobe, 16'h0000);

        hw_set[3*DW + 4] = 1'b1;
        @(posedge sysclk); #1;
        hw_set[3*DW + 4] = 1'b0;
        do_read("w1c_set", 8'h0C, 32'h10, 1'b0, 16'h0008);
        hw_set[3*DW + 4] = 1'b1;
        do_write(8'h0C, 4'hF, 32'h10);
        hw_set[3*DW + 4] = 1'b0;
        do_read("w1c_race", 8'h0C, 32'h10, 1'b0, 16'h0008);
        do_write(8'h0C, 4'hF, 32'h10);
        do_read("w1c_clr", 8'h0C, 32'h0, 1'b0, 16'h0008);

        hw_set[5*DW +: DW] = 32'h3;
        @(posedge sysclk); #1;
        hw_set[5*DW +: DW] = '0;
        do_read("rc_first", 8'h14, 32'h3, 1'b0, 16'h0020);
        chk("rc_cleared_q", qw(5), 32'h0);
        do_read("rc_second", 8'h14, 32'h0, 1'b0, 16'h0020);

        do_read("oor_rd", 8'h40, 32'h0, 1'b1, 16'h0000);
        do_write(8'h40, 4'hF, 32'hDEAD_BEEF);
        chk("oor_wr_err", reg_error, 1'b1);
        chk("oor_wr_wstb", reg_wstrobe, 16'h0000);

        hw_set[4*DW +: DW] = 32'h1234_5678;
        do_write(8'h10, 4'hF, 32'hFFFF_FFFF);
        chk("ro_wr_err", reg_error, 1'b1);
        chk("ro_val", qw(4), 32'h1234_5678);
        @(posedge sysclk); #1;
        chk("ro_err_pulse", reg_error, 1'b0);
        do_read("ro_rd", 8'h10, 32'h1234_5678, 1'b0, 16'h0010);
        hw_set[4*DW +: DW] = '0;

        do_write(8'h04, 4'h0, 32'hFFFF_FFFF);
        chk("be0_val", qw(1), 32'h0);
        chk("be0_wstb", reg_wstrobe, 16'h0002);

        reg_addr = 8'h04; reg_be = 4'hF; reg_writedata = 32'hCAFE_F00D;
        reg_read = 1'b1; reg_write = 1'b1;
        @(posedge sysclk); #1;
        reg_read = 1'b0; reg_write = 1'b0;
        chk("rw_wstb", reg_wstrobe, 16'h0002);
        chk("rw_hold_wait", reg_waitrequest, 1'b1);
        chk("rw_hold_valid", reg_readdatavalid, 1'b0);
        chk("rw_val", qw(1), 32'hCAFE_F00D);
        @(posedge sysclk); #1;
        chk("rw_valid", reg_readdatavalid, 1'b1);
        chk("rw_data", reg_readdata, 32'hCAFE_F00D);
        chk("rw_rstb", reg_rstrobe, 16'h0002);
        @(posedge sysclk); #1;
        chk("rw_idle_wait", reg_waitrequest, 1'b0);

        reg_addr = 8'h08; reg_read = 1'b1;
        @(posedge sysclk); #1;
        reg_read = 1'b0;
        chk("abort_valid_pre", reg_readdatavalid, 1'b1);
        sysrst_n = 1'b0;
        #1;
        chk("abort_valid_rst", reg_readdatavalid, 1'b0);
        @(posedge sysclk); #1;
        sysrst_n = 1'b1;
        any_valid = 1'b0;
        repeat (4) begin
            @(posedge sysclk); #1;
            any_valid |= reg_readdatavalid;
        end
        chk("abort_no_valid", any_valid, 1'b0);
        chk("abort_reg1_reset", qw(1), 32'h0);
        chk("abort_wait", reg_waitrequest, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
